// File: rtl/axil_csr_fifo_slave.sv
// AXI4-Lite slave exposing read/write CSRs and word FIFOs in both directions (PS->PL, PL->PS).
// Unmapped words respond DECERR. Full-FIFO pushes and empty-FIFO pops respond SLVERR.
module axil_csr_fifo_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 10,
    parameter int C_NUM_CSR          = 4,
    parameter int C_NUM_FIFO         = 1,
    parameter int C_FIFO_DEPTH       = 4
) (
    input  logic                                         aclk,
    input  logic                                         areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                s_axi_awaddr,
    input  logic [2:0]                                   s_axi_awprot,
    input  logic                                         s_axi_awvalid,
    output logic                                         s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]              s_axi_wstrb,
    input  logic                                         s_axi_wvalid,
    output logic                                         s_axi_wready,
    output logic [1:0]                                   s_axi_bresp,
    output logic                                         s_axi_bvalid,
    input  logic                                         s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                s_axi_araddr,
    input  logic [2:0]                                   s_axi_arprot,
    input  logic                                         s_axi_arvalid,
    output logic                                         s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                s_axi_rdata,
    output logic [1:0]                                   s_axi_rresp,
    output logic                                         s_axi_rvalid,
    input  logic                                         s_axi_rready,
    output logic [C_NUM_CSR*C_S_AXI_DATA_WIDTH-1:0]      csr_o,
    output logic [C_NUM_FIFO*C_S_AXI_DATA_WIDTH-1:0]     ps2pl_data_o,
    output logic [C_NUM_FIFO-1:0]                        ps2pl_v_o,
    input  logic [C_NUM_FIFO-1:0]                        ps2pl_yumi_i,
    input  logic [C_NUM_FIFO*C_S_AXI_DATA_WIDTH-1:0]     pl2ps_data_i,
    input  logic [C_NUM_FIFO-1:0]                        pl2ps_v_i,
    output logic [C_NUM_FIFO-1:0]                        pl2ps_ready_o
);

    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int NB  = DW / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = C_S_AXI_ADDR_WIDTH - LSB;
    localparam int PW  = $clog2(C_FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int N   = C_NUM_CSR;
    localparam int F   = C_NUM_FIFO;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    logic [DW-1:0] csr_q      [N];
    logic [DW-1:0] ps2pl_mem  [F][C_FIFO_DEPTH];
    logic [DW-1:0] pl2ps_mem  [F][C_FIFO_DEPTH];
    logic [PW-1:0] ps2pl_wptr [F], ps2pl_rptr [F];
    logic [PW-1:0] pl2ps_wptr [F], pl2ps_rptr [F];
    logic [CW-1:0] ps2pl_cnt  [F], pl2ps_cnt  [F];

    logic          wr_ready_q, rd_ready_q;
    logic          bvalid_q, rvalid_q;
    resp_e         bresp_q, rresp_q;
    logic [DW-1:0] rdata_q;

    logic          wr_fire, rd_fire;
    logic [IW-1:0] w_idx, r_idx;
    resp_e         wr_resp, rd_resp;
    logic [DW-1:0] rd_data;
    logic [N-1:0]  csr_we;
    logic [F-1:0]  ps2pl_push, ps2pl_pop, pl2ps_push, pl2ps_pop;

    // Protection bits and byte-offset address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};

    assign s_axi_awready = wr_ready_q;
    assign s_axi_wready  = wr_ready_q;
    assign s_axi_arready = rd_ready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;

    assign wr_fire = wr_ready_q & s_axi_awvalid & s_axi_wvalid;
    assign rd_fire = rd_ready_q & s_axi_arvalid;
    assign w_idx   = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:LSB];
    assign r_idx   = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:LSB];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        csr_we     = '0;
        ps2pl_push = '0;
        wr_resp    = RESP_DECERR;
        for (int i = 0; i < N; i++) begin
            if (w_idx == IW'(i)) begin
                csr_we[i] = wr_fire;
                wr_resp   = RESP_OKAY;
            end
        end
        for (int f = 0; f < F; f++) begin
            if (w_idx == IW'(N + f)) begin
                wr_resp       = (ps2pl_cnt[f] == CW'(C_FIFO_DEPTH)) ? RESP_SLVERR : RESP_OKAY;
                ps2pl_push[f] = wr_fire & (ps2pl_cnt[f] != CW'(C_FIFO_DEPTH));
            end
            if (w_idx == IW'(N + F + f) || w_idx == IW'(N + 2*F + f)) begin
                wr_resp = RESP_OKAY;
            end
        end
    end

    always_comb begin
        rd_data   = '0;
        rd_resp   = RESP_DECERR;
        pl2ps_pop = '0;
        for (int i = 0; i < N; i++) begin
            if (r_idx == IW'(i)) begin
                rd_data = csr_q[i];
                rd_resp = RESP_OKAY;
            end
        end
        for (int f = 0; f < F; f++) begin
            if (r_idx == IW'(N + f)) begin
                rd_data = DW'(CW'(C_FIFO_DEPTH) - ps2pl_cnt[f]);
                rd_resp = RESP_OKAY;
            end
            if (r_idx == IW'(N + F + f)) begin
                if (pl2ps_cnt[f] != '0) begin
                    rd_data      = pl2ps_mem[f][pl2ps_rptr[f]];
                    rd_resp      = RESP_OKAY;
                    pl2ps_pop[f] = rd_fire;
                end else begin
                    rd_resp = RESP_SLVERR;
                end
            end
            if (r_idx == IW'(N + 2*F + f)) begin
                rd_data = DW'(pl2ps_cnt[f]);
                rd_resp = RESP_OKAY;
            end
        end
    end

    always_comb begin
        csr_o         = '0;
        ps2pl_data_o  = '0;
        ps2pl_v_o     = '0;
        pl2ps_ready_o = '0;
        ps2pl_pop     = '0;
        pl2ps_push    = '0;
        for (int i = 0; i < N; i++) csr_o[i*DW +: DW] = csr_q[i];
        for (int f = 0; f < F; f++) begin
            ps2pl_data_o[f*DW +: DW] = ps2pl_mem[f][ps2pl_rptr[f]];
            ps2pl_v_o[f]     = (ps2pl_cnt[f] != '0);
            ps2pl_pop[f]     = ps2pl_yumi_i[f] & ps2pl_v_o[f];
            pl2ps_ready_o[f] = (pl2ps_cnt[f] != CW'(C_FIFO_DEPTH)) & ~areset;
            pl2ps_push[f]    = pl2ps_v_i[f] & pl2ps_ready_o[f];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ready_q <= 1'b0;
            rd_ready_q <= 1'b0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            for (int i = 0; i < N; i++) csr_q[i] <= '0;
            for (int f = 0; f < F; f++) begin
                ps2pl_wptr[f] <= '0; ps2pl_rptr[f] <= '0; ps2pl_cnt[f] <= '0;
                pl2ps_wptr[f] <= '0; pl2ps_rptr[f] <= '0; pl2ps_cnt[f] <= '0;
            end
        end else begin
            wr_ready_q <= s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~wr_ready_q;
            rd_ready_q <= s_axi_arvalid & ~rvalid_q & ~rd_ready_q;

            if (wr_fire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (s_axi_bready) begin
                bvalid_q <= 1'b0;
            end

            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rresp_q  <= rd_resp;
                rdata_q  <= rd_data;
            end else if (s_axi_rready) begin
                rvalid_q <= 1'b0;
            end

            for (int i = 0; i < N; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if (csr_we[i] && s_axi_wstrb[b]) csr_q[i][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end

            for (int f = 0; f < F; f++) begin
                if (ps2pl_push[f]) ps2pl_wptr[f] <= ps2pl_wptr[f] + PW'(1);
                if (ps2pl_pop[f])  ps2pl_rptr[f] <= ps2pl_rptr[f] + PW'(1);
                case ({ps2pl_push[f], ps2pl_pop[f]})
                    2'b10:   ps2pl_cnt[f] <= ps2pl_cnt[f] + CW'(1);
                    2'b01:   ps2pl_cnt[f] <= ps2pl_cnt[f] - CW'(1);
                    default: ;
                endcase
                if (pl2ps_push[f]) pl2ps_wptr[f] <= pl2ps_wptr[f] + PW'(1);
                if (pl2ps_pop[f])  pl2ps_rptr[f] <= pl2ps_rptr[f] + PW'(1);
                case ({pl2ps_push[f], pl2ps_pop[f]})
                    2'b10:   pl2ps_cnt[f] <= pl2ps_cnt[f] + CW'(1);
                    2'b01:   pl2ps_cnt[f] <= pl2ps_cnt[f] - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    // NOTE: FIFO storage is deliberately left unreset; the pointers and counts define validity.
    always_ff @(posedge aclk) begin
        for (int f = 0; f < F; f++) begin
            if (ps2pl_push[f]) ps2pl_mem[f][ps2pl_wptr[f]] <= s_axi_wdata;
            if (pl2ps_push[f]) pl2ps_mem[f][pl2ps_wptr[f]] <= pl2ps_data_i[f*DW +: DW];
        end
    end

endmodule
